// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared types, defaults and width helper for the frame read path
//
// Contents:
//   N_FRAMES_DEF, FRAME_PIXELS_DEF : default geometry of the frame memory
//   pixel_t                        : 24-bit pixel word
//   state_e                        : read sequencer states
//   idx_width(n)                   : bits needed to hold 0..n-1 (minimum 1)
package video_pkg;

    localparam int N_FRAMES_DEF     = 24;
    localparam int FRAME_PIXELS_DEF = 2048;
    localparam int PIXEL_W          = 24;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_STREAM,
        S_DONE
    } state_e;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - modulo counter 0..MAX with clear and terminal flag
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   inc      : advance by one, wrapping to 0 after MAX
//   clr      : synchronous clear, wins over inc
//   count    : current value
//   at_max   : count equals MAX
module wrap_counter
    import video_pkg::*;
#(
    parameter int MAX = 1,
    parameter int W   = idx_width(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         at_max
);

    logic [W-1:0] count_q;

    assign at_max = (count_q == W'(MAX));
    assign count  = count_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= at_max ? '0 : count_q + 1'b1;
        end
    end

endmodule

// File: rtl/frame_reader.sv
// rtl/frame_reader.sv - frame memory read sequencer feeding a valid/ready pixel stream
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start, loop        : begin playback from frame 0; wrap after last frame
//   rd_image           : memory read strobe (combinational)
//   address_image      : memory address (combinational, valid with rd_image)
//   data_out           : memory read data, settles at the negedge of the read cycle
//   pixel_data         : registered pixel word
//   pixel_valid        : pixel_data valid
//   pixel_ready        : downstream accepts
//   pixel_index        : index of presented pixel within its frame
//   frame_index        : frame of presented pixel
//   frame_start        : presented pixel is index 0
//   frame_last         : presented pixel is the last of its frame
//   done               : playback finished
module frame_reader
    import video_pkg::*;
#(
    parameter int N_FRAMES     = N_FRAMES_DEF,
    parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
    parameter int TOTAL_PIXELS = N_FRAMES * FRAME_PIXELS,
    parameter int HOLD_FRAMES  = 1,
    parameter int AW           = idx_width(TOTAL_PIXELS),
    parameter int PW           = idx_width(FRAME_PIXELS),
    parameter int FW           = idx_width(N_FRAMES),
    parameter int HW           = idx_width(HOLD_FRAMES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          loop,
    output logic          rd_image,
    output logic [AW-1:0] address_image,
    input  pixel_t        data_out,
    output pixel_t        pixel_data,
    output logic          pixel_valid,
    input  logic          pixel_ready,
    output logic [PW-1:0] pixel_index,
    output logic [FW-1:0] frame_index,
    output logic          frame_start,
    output logic          frame_last,
    output logic          done
);

    state_e        state_q;
    pixel_t        pixel_data_q;
    logic          pixel_valid_q, done_q, frame_start_q, frame_last_q;
    logic [AW-1:0] base_q, base_d;

    logic [PW-1:0] pix_cnt, pix_next, rd_pix;
    logic [FW-1:0] frm_cnt;
    logic [HW-1:0] unused_hold_cnt;
    logic          pix_at_max, hold_at_max, frm_at_max;
    logic          hs, end_of_video, adv, restart;

    // The counters hold the position of the presented pixel; the next read
    // position is derived from them combinationally.
    assign hs           = (state_q == S_STREAM) && pixel_ready;
    assign end_of_video = pix_at_max && hold_at_max && frm_at_max && !loop;
    assign adv          = hs && !end_of_video;
    assign restart      = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Gating with rst keeps a mid-stream reset from issuing one last read.
    assign rd_image = !rst && ((state_q == S_PRIME) || adv);

    assign pix_next = pix_at_max ? '0 : pix_cnt + 1'b1;

    always_comb begin
        base_d = base_q;
        if (pix_at_max && hold_at_max) begin
            base_d = frm_at_max ? '0 : base_q + AW'(FRAME_PIXELS);
        end
    end

    // PRIME reads pixel 0 of the (cleared) current frame; a handshake reads the next one.
    assign rd_pix        = (state_q == S_PRIME) ? '0 : pix_next;
    assign address_image = ((state_q == S_PRIME) ? base_q : base_d) + AW'(rd_pix);

    wrap_counter #(.MAX(FRAME_PIXELS - 1), .W(PW)) u_pix_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (adv),
        .clr    (restart),
        .count  (pix_cnt),
        .at_max (pix_at_max)
    );

    wrap_counter #(.MAX(HOLD_FRAMES - 1), .W(HW)) u_hold_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (adv && pix_at_max),
        .clr    (restart),
        .count  (unused_hold_cnt),
        .at_max (hold_at_max)
    );

    wrap_counter #(.MAX(N_FRAMES - 1), .W(FW)) u_frm_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (adv && pix_at_max && hold_at_max),
        .clr    (restart),
        .count  (frm_cnt),
        .at_max (frm_at_max)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pixel_data_q  <= '0;
            pixel_valid_q <= 1'b0;
            done_q        <= 1'b0;
            frame_start_q <= 1'b0;
            frame_last_q  <= 1'b0;
            base_q        <= '0;
        end else begin
            if (rd_image) begin
                pixel_data_q  <= data_out;
                frame_start_q <= (rd_pix == '0);
                frame_last_q  <= (rd_pix == PW'(FRAME_PIXELS - 1));
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_PRIME;
                        base_q  <= '0;
                    end
                end
                S_PRIME: begin
                    state_q       <= S_STREAM;
                    pixel_valid_q <= 1'b1;
                end
                S_STREAM: begin
                    if (hs) begin
                        if (end_of_video) begin
                            state_q       <= S_DONE;
                            pixel_valid_q <= 1'b0;
                            done_q        <= 1'b1;
                        end else begin
                            base_q <= base_d;
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_q <= S_PRIME;
                        done_q  <= 1'b0;
                        base_q  <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pixel_data  = pixel_data_q;
    assign pixel_valid = pixel_valid_q;
    assign done        = done_q;
    assign frame_start = frame_start_q;
    assign frame_last  = frame_last_q;
    assign pixel_index = pix_cnt;
    assign frame_index = frm_cnt;

endmodule

// File: tb/tb_frame_reader.sv
// tb/tb_frame_reader.sv - self-checking bench for frame_reader
module tb_frame_reader;

    localparam int NF = 3;
    localparam int FP = 4;
    localparam int HF = 2;
    localparam int NPIX = NF * FP * HF;

    logic        clk = 1'b0;
    logic        rst, start, loop, pixel_ready;
    logic        rd_image, pixel_valid, frame_start, frame_last, done;
    logic [3:0]  address_image;
    logic [23:0] data_out, pixel_data;
    logic [1:0]  pixel_index;
    logic [1:0]  frame_index;

    int total = 0;
    int bad   = 0;

    frame_reader #(
        .N_FRAMES     (NF),
        .FRAME_PIXELS (FP),
        .HOLD_FRAMES  (HF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .loop          (loop),
        .rd_image      (rd_image),
        .address_image (address_image),
        .data_out      (data_out),
        .pixel_data    (pixel_data),
        .pixel_valid   (pixel_valid),
        .pixel_ready   (pixel_ready),
        .pixel_index   (pixel_index),
        .frame_index   (frame_index),
        .frame_start   (frame_start),
        .frame_last    (frame_last),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Frame memory model: read data equals the address.
    initial data_out = '0;
    always @(negedge clk) if (rd_image) data_out <= 24'(address_image);

    typedef struct {
        logic ready;
        logic exp_valid;
        logic exp_rd;
        int   exp_addr;
        int   exp_data;
        int   exp_pix;
        int   exp_frm;
        logic exp_fs;
        logic exp_fl;
        logic exp_done;
    } vec_t;

    vec_t vt[NPIX + 2];

    function automatic int ideal_addr(input int i);
        int j;
        j = i % NPIX;
        return ((j / (FP * HF)) % NF) * FP + (j % FP);
    endfunction

    function automatic int ideal_frm(input int i);
        return (i % NPIX) / (FP * HF);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [23:0] rx[NPIX];
    int          got;
    logic        prev_stall;
    logic [23:0] prev_data;

    initial begin
        // Table for the loop=0, always-ready run: entry 0 is PRIME, then 24 pixels, then DONE.
        for (int k = 0; k < NPIX + 2; k++) begin
            vt[k].ready     = 1'b1;
            vt[k].exp_valid = (k >= 1) && (k <= NPIX);
            vt[k].exp_rd    = (k < NPIX);
            vt[k].exp_addr  = ideal_addr(k);
            vt[k].exp_data  = (k >= 1) ? ideal_addr(k - 1) : 0;
            vt[k].exp_pix   = (k >= 1) ? (k - 1) % FP : 0;
            vt[k].exp_frm   = (k >= 1) ? ideal_frm(k - 1) : 0;
            vt[k].exp_fs    = (k >= 1) && (((k - 1) % FP) == 0);
            vt[k].exp_fl    = (k >= 1) && (((k - 1) % FP) == FP - 1);
            vt[k].exp_done  = (k == NPIX + 1);
        end
        vt[0].exp_addr = 0;

        rst = 1'b1; start = 1'b0; loop = 1'b0; pixel_ready = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rst_valid", pixel_valid, 0);
        chk("rst_rd", rd_image, 0);
        chk("rst_done", done, 0);
        chk("rst_data", pixel_data, 0);
        chk("rst_pix", pixel_index, 0);
        chk("rst_frm", frame_index, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_fl", frame_last, 0);

        // Test 1: table-driven full run, loop=0.
        step(); rst = 1'b0;
        step(); start = 1'b1;
        step(); start = 1'b0;
        for (int k = 0; k < NPIX + 2; k++) begin
            pixel_ready = vt[k].ready;
            @(negedge clk);
            chk($sformatf("t1_valid[%0d]", k), pixel_valid, vt[k].exp_valid);
            chk($sformatf("t1_rd[%0d]", k), rd_image, vt[k].exp_rd);
            chk($sformatf("t1_done[%0d]", k), done, vt[k].exp_done);
            if (vt[k].exp_rd)
                chk($sformatf("t1_addr[%0d]", k), address_image, vt[k].exp_addr);
            if (vt[k].exp_valid) begin
                chk($sformatf("t1_data[%0d]", k), pixel_data, vt[k].exp_data);
                chk($sformatf("t1_pix[%0d]", k), pixel_index, vt[k].exp_pix);
                chk($sformatf("t1_frm[%0d]", k), frame_index, vt[k].exp_frm);
                chk($sformatf("t1_fs[%0d]", k), frame_start, vt[k].exp_fs);
                chk($sformatf("t1_fl[%0d]", k), frame_last, vt[k].exp_fl);
            end
            step();
        end

        // Test 2: random back-pressure, restart from DONE.
        start = 1'b1;
        step(); start = 1'b0;
        got = 0; prev_stall = 1'b0; prev_data = '0;
        for (int c = 0; c < 400 && got < NPIX; c++) begin
            pixel_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (prev_stall) begin
                chk("t2_stall_valid", pixel_valid, 1);
                chk("t2_stall_hold", pixel_data, prev_data);
            end
            if (pixel_valid && !pixel_ready) chk("t2_stall_no_rd", rd_image, 0);
            if (pixel_valid && pixel_ready) begin
                rx[got] = pixel_data;
                got++;
            end
            prev_stall = pixel_valid && !pixel_ready;
            prev_data  = pixel_data;
            step();
        end
        chk("t2_count", got, NPIX);
        for (int i = 0; i < got; i++) chk($sformatf("t2_seq[%0d]", i), rx[i], ideal_addr(i));
        @(negedge clk);
        chk("t2_done", done, 1);

        // Test 3: loop=1 wraps with no bubble, then reset in the middle of frame 1.
        step(); loop = 1'b1; pixel_ready = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        step();
        for (int i = 0; i < NPIX + 10; i++) begin
            @(negedge clk);
            chk($sformatf("t3_valid[%0d]", i), pixel_valid, 1);
            chk($sformatf("t3_data[%0d]", i), pixel_data, ideal_addr(i));
            if (i == NPIX) chk("t3_wrap_frm", frame_index, 0);
            step();
        end
        rst = 1'b1;
        step(); rst = 1'b0; loop = 1'b0;
        @(negedge clk);
        chk("t3_rst_valid", pixel_valid, 0);
        chk("t3_rst_rd", rd_image, 0);
        chk("t3_rst_data", pixel_data, 0);
        chk("t3_rst_done", done, 0);

        // Test 4: start ignored while streaming; start in DONE restarts 2 cycles later.
        step(); start = 1'b1;
        step(); start = 1'b0;
        @(negedge clk);
        chk("t4_prime_rd", rd_image, 1);
        chk("t4_prime_addr", address_image, 0);
        chk("t4_prime_valid", pixel_valid, 0);
        step();
        @(negedge clk);
        chk("t4_first_valid", pixel_valid, 1);
        chk("t4_first_data", pixel_data, 0);
        for (int i = 1; i < NPIX; i++) begin
            step(); start = (i == 5);
            @(negedge clk);
            chk($sformatf("t4_valid[%0d]", i), pixel_valid, 1);
            chk($sformatf("t4_data[%0d]", i), pixel_data, ideal_addr(i));
        end
        step(); start = 1'b0;
        @(negedge clk);
        chk("t4_done", done, 1);
        chk("t4_done_valid", pixel_valid, 0);
        step(); start = 1'b1;
        step(); start = 1'b0;
        @(negedge clk);
        chk("t4_re_prime_rd", rd_image, 1);
        chk("t4_re_prime_addr", address_image, 0);
        chk("t4_re_prime_valid", pixel_valid, 0);
        step();
        @(negedge clk);
        chk("t4_re_valid", pixel_valid, 1);
        chk("t4_re_data", pixel_data, 0);
        chk("t4_re_fs", frame_start, 1);
        chk("t4_re_done", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
